hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 21 ++
 rtl/hazard_match.sv | 20 ++
 rtl/hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_hazard_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared core package for the hazard unit: FSM state encodings, register
// constants and counter limits used by hazard_unit and hazard_match.
package hazard_unit_pkg;

   localparam int REG_ADDR_W = 5;

   // Register x0 is hardwired to zero, so it never carries a dependency
   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   // Canonical NOP (addi x0, x0, 0) that a flushed pipeline register holds
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [31:0] STALL_COUNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_DRAIN  = 2'd1,
      HZ_HALTED = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// Combinational comparator: does one ID source register depend on the
// destination of one later pipeline stage? x0 never matches.
module hazard_match
   import hazard_unit_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] i_rs_addr,
   input  logic                  i_uses_rs,
   input  logic                  i_stage_valid,
   input  logic                  i_stage_reg_write,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   output logic                  o_match
);

   // A match needs a real source, a live writing stage and equal addresses
   always_comb begin
      o_match = (i_rs_addr != REG_X0) && i_uses_rs && i_stage_valid &&
                i_stage_reg_write && (i_rd_addr == i_rs_addr);
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stalls/flushes the front end on data hazards and
// redirects, and drains the pipeline when a halt instruction issues.
// Optional macro HAZARD_FORWARD_EN: when defined, EX/MEM forwarding exists
// and only load-use dependencies stall; otherwise any EX or MEM dependency
// stalls. Ports and FSM are identical in both builds.
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   input  logic                  i_id_halt,
   input  logic                  i_ex_valid,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   input  logic                  i_ex_reg_write,
   input  logic                  i_ex_mem_read,
   input  logic                  i_ex_redirect,
   input  logic                  i_mem_valid,
   input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
   input  logic                  i_mem_reg_write,
   input  logic                  i_wb_retire_halt,
   output logic                  o_pc_stall,
   output logic                  o_ifid_stall,
   output logic                  o_ifid_flush,
   output logic                  o_idex_flush,
   output logic [1:0]            o_state,
   output logic                  o_halted,
   output logic [31:0]           o_stall_count
);

   hz_state_e   state_q, state_d;
   logic        halted_q, halted_d;
   logic [31:0] stall_count_q, stall_count_d;

   logic ex_rs1_match, ex_rs2_match, mem_rs1_match, mem_rs2_match;
   logic load_use, hazard;

   hazard_match u_ex_rs1 (
      .i_rs_addr(i_id_rs1_addr), .i_uses_rs(i_id_uses_rs1),
      .i_stage_valid(i_ex_valid), .i_stage_reg_write(i_ex_reg_write),
      .i_rd_addr(i_ex_rd_addr), .o_match(ex_rs1_match)
   );

   hazard_match u_ex_rs2 (
      .i_rs_addr(i_id_rs2_addr), .i_uses_rs(i_id_uses_rs2),
      .i_stage_valid(i_ex_valid), .i_stage_reg_write(i_ex_reg_write),
      .i_rd_addr(i_ex_rd_addr), .o_match(ex_rs2_match)
   );

   hazard_match u_mem_rs1 (
      .i_rs_addr(i_id_rs1_addr), .i_uses_rs(i_id_uses_rs1),
      .i_stage_valid(i_mem_valid), .i_stage_reg_write(i_mem_reg_write),
      .i_rd_addr(i_mem_rd_addr), .o_match(mem_rs1_match)
   );

   hazard_match u_mem_rs2 (
      .i_rs_addr(i_id_rs2_addr), .i_uses_rs(i_id_uses_rs2),
      .i_stage_valid(i_mem_valid), .i_stage_reg_write(i_mem_reg_write),
      .i_rd_addr(i_mem_rd_addr), .o_match(mem_rs2_match)
   );

   // A load in EX cannot forward in time, so its consumer in ID must wait
   always_comb begin
      load_use = i_id_valid && i_ex_mem_read && (ex_rs1_match || ex_rs2_match);
   end

`ifdef HAZARD_FORWARD_EN
   // Forwarding covers ALU results; only load-use stalls remain
   always_comb begin
      hazard = load_use;
   end
`else
   // No forwarding: any pending EX or MEM write to a source stalls (WB is
   // covered by register-file write-through)
   always_comb begin
      hazard = load_use || (i_id_valid && (ex_rs1_match || ex_rs2_match ||
                                           mem_rs1_match || mem_rs2_match));
   end
`endif

   // Next-state, halted flag and saturating stall counter
   always_comb begin
      state_d       = state_q;
      stall_count_d = stall_count_q;
      case (state_q)
         HZ_RUN: begin
            if (!i_ex_redirect) begin
               if (hazard) begin
                  if (stall_count_q != STALL_COUNT_MAX) begin
                     stall_count_d = stall_count_q + 32'd1;
                  end
               end else if (i_id_valid && i_id_halt) begin
                  state_d = HZ_DRAIN;
               end
            end
         end
         HZ_DRAIN: begin
            if (i_ex_redirect) begin
               state_d = HZ_RUN;
            end else if (i_wb_retire_halt) begin
               state_d = HZ_HALTED;
            end
         end
         HZ_HALTED: begin
            state_d = HZ_HALTED;
         end
         default: begin
            state_d = HZ_RUN;
         end
      endcase
      halted_d = (state_d == HZ_HALTED);
   end

   // FSM and status registers; reset discards any drain progress
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= HZ_RUN;
         halted_q      <= 1'b0;
         stall_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         halted_q      <= halted_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Zero-latency pipeline controls from current state and inputs
   always_comb begin
      o_pc_stall   = 1'b0;
      o_ifid_stall = 1'b0;
      o_ifid_flush = 1'b0;
      o_idex_flush = 1'b0;
      case (state_q)
         HZ_DRAIN: begin
            if (i_ex_redirect) begin
               o_ifid_flush = 1'b1;
               o_idex_flush = 1'b1;
            end else begin
               o_pc_stall   = 1'b1;
               o_ifid_flush = 1'b1;
            end
         end
         HZ_HALTED: begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
         end
         default: begin
            if (i_ex_redirect) begin
               o_ifid_flush = 1'b1;
               o_idex_flush = 1'b1;
            end else if (hazard) begin
               o_pc_stall   = 1'b1;
               o_ifid_stall = 1'b1;
               o_idex_flush = 1'b1;
            end
         end
      endcase
   end

   assign o_state       = state_q;
   assign o_halted      = halted_q;
   assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Expected control/status words are
// queued when each vector is driven and popped once the DUT has settled.
// Honours HAZARD_FORWARD_EN the same way the design does.
module tb_hazard_unit;

   logic        i_clk, i_rst;
   logic        i_id_valid, i_id_uses_rs1, i_id_uses_rs2, i_id_halt;
   logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr, i_mem_rd_addr;
   logic        i_ex_valid, i_ex_reg_write, i_ex_mem_read, i_ex_redirect;
   logic        i_mem_valid, i_mem_reg_write, i_wb_retire_halt;
   logic        o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush, o_halted;
   logic [1:0]  o_state;
   logic [31:0] o_stall_count;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // {pc_stall, ifid_stall, ifid_flush, idex_flush}
   localparam logic [3:0] CTL_NONE  = 4'b0000;
   localparam logic [3:0] CTL_STALL = 4'b1101;
   localparam logic [3:0] CTL_REDIR = 4'b0011;
   localparam logic [3:0] CTL_DRAIN = 4'b1010;
   localparam logic [3:0] CTL_HALT  = 4'b1101;
   localparam logic [3:0] CTL_ALU   = FWD ? CTL_NONE : CTL_STALL;
   localparam logic       INC_ALU   = !FWD;

   typedef struct packed {
      logic       idv;  logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
      logic       halt; logic exv; logic [4:0] exrd; logic exrw; logic exmr;
      logic       redir; logic memv; logic [4:0] memrd; logic memrw; logic retire;
   } stim_t;

   typedef struct {
      string      name;
      stim_t      s;
      logic       rst;
      logic [3:0] ctl;
      logic [1:0] st;
      logic       hl;
      logic       inc;
   } step_t;

   typedef struct {
      string       name;
      logic [38:0] v;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_cnt = 32'd0;

   hazard_unit dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_id_valid(i_id_valid), .i_id_rs1_addr(i_id_rs1_addr),
      .i_id_rs2_addr(i_id_rs2_addr), .i_id_uses_rs1(i_id_uses_rs1),
      .i_id_uses_rs2(i_id_uses_rs2), .i_id_halt(i_id_halt),
      .i_ex_valid(i_ex_valid), .i_ex_rd_addr(i_ex_rd_addr),
      .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read),
      .i_ex_redirect(i_ex_redirect),
      .i_mem_valid(i_mem_valid), .i_mem_rd_addr(i_mem_rd_addr),
      .i_mem_reg_write(i_mem_reg_write), .i_wb_retire_halt(i_wb_retire_halt),
      .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall),
      .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
      .o_state(o_state), .o_halted(o_halted), .o_stall_count(o_stall_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, required finish before 100us");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic stim_t mk_s(input logic idv, input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2, input logic halt,
                                  input logic exv, input logic [4:0] exrd, input logic exrw,
                                  input logic exmr, input logic redir, input logic memv,
                                  input logic [4:0] memrd, input logic memrw, input logic retire);
      stim_t s;
      s = '{idv, rs1, u1, rs2, u2, halt, exv, exrd, exrw, exmr, redir, memv, memrd, memrw, retire};
      return s;
   endfunction

   function automatic step_t mk(input string name, input stim_t s, input logic rst,
                                input logic [3:0] ctl, input logic [1:0] st,
                                input logic hl, input logic inc);
      step_t t;
      t.name = name; t.s = s; t.rst = rst; t.ctl = ctl; t.st = st; t.hl = hl; t.inc = inc;
      return t;
   endfunction

   function automatic logic [38:0] obs();
      return {o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush, o_state, o_halted, o_stall_count};
   endfunction

   // Common vectors
   function automatic stim_t idle();
      return mk_s(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
   endfunction
   function automatic stim_t load5();
      return mk_s(1,5,1,0,0,0, 1,5,1,1,0, 0,0,0,0);
   endfunction
   function automatic stim_t load5_redir();
      return mk_s(1,5,1,0,0,0, 1,5,1,1,1, 0,0,0,0);
   endfunction
   function automatic stim_t halt_id();
      return mk_s(1,0,0,0,0,1, 0,0,0,0,0, 0,0,0,0);
   endfunction

   // Drive one vector at the negedge and queue what the DUT must show
   task automatic applyStimulus(input step_t t);
      exp_t e;
      i_rst            = t.rst;
      i_id_valid       = t.s.idv;   i_id_rs1_addr = t.s.rs1;  i_id_uses_rs1 = t.s.u1;
      i_id_rs2_addr    = t.s.rs2;   i_id_uses_rs2 = t.s.u2;   i_id_halt     = t.s.halt;
      i_ex_valid       = t.s.exv;   i_ex_rd_addr  = t.s.exrd; i_ex_reg_write = t.s.exrw;
      i_ex_mem_read    = t.s.exmr;  i_ex_redirect = t.s.redir;
      i_mem_valid      = t.s.memv;  i_mem_rd_addr = t.s.memrd; i_mem_reg_write = t.s.memrw;
      i_wb_retire_halt = t.s.retire;
      e.name = t.name;
      e.v    = {t.ctl, t.st, t.hl, exp_cnt};
      sb.push_back(e);
      vectors++;
   endtask

   // Update the expected counter for the coming edge, then move to next negedge
   task automatic advance(input step_t t);
      if (t.rst) exp_cnt = 32'd0;
      else if (t.inc && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("reset_hold",    idle(), 1, CTL_NONE, 2'd0, 0, 0));
      q.push_back(mk("reset_release", idle(), 0, CTL_NONE, 2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_load_use();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("load_use_stall",   load5(),                                    0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("load_use_release", mk_s(1,5,1,0,0,0, 0,0,0,0,0, 0,0,0,0),      0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("load_use_rs2",     mk_s(1,0,0,12,1,0, 1,12,1,1,0, 0,0,0,0),    0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("uses_rs1_clear",   mk_s(1,5,0,0,0,0, 1,5,1,1,0, 0,0,0,0),      0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("ex_invalid",       mk_s(1,5,1,0,0,0, 0,5,1,1,0, 0,0,0,0),      0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("addr_differ",      mk_s(1,5,1,6,1,0, 1,7,1,1,0, 0,0,0,0),      0, CTL_NONE,  2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_redirect();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("redirect_over_hazard", load5_redir(), 0, CTL_REDIR, 2'd0, 0, 0));
      q.push_back(mk("redirect_after",       idle(),        0, CTL_NONE,  2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_x0_and_alu();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("x0_ex_load",    mk_s(1,0,0,0,1,0, 1,0,1,1,0, 0,0,0,0),   0, CTL_NONE, 2'd0, 0, 0));
      q.push_back(mk("x0_mem_write",  mk_s(1,0,1,0,0,0, 0,0,0,0,0, 1,0,1,0),   0, CTL_NONE, 2'd0, 0, 0));
      q.push_back(mk("alu_ex_match",  mk_s(1,7,1,0,0,0, 1,7,1,0,0, 0,0,0,0),   0, CTL_ALU,  2'd0, 0, INC_ALU));
      q.push_back(mk("alu_mem_match", mk_s(1,0,0,9,1,0, 0,0,0,0,0, 1,9,1,0),   0, CTL_ALU,  2'd0, 0, INC_ALU));
      q.push_back(mk("mem_no_write",  mk_s(1,0,0,9,1,0, 0,0,0,0,0, 1,9,0,0),   0, CTL_NONE, 2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_back_to_back();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("b2b_stall_0", load5(),       0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("b2b_stall_1", load5(),       0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("b2b_redir",   load5_redir(), 0, CTL_REDIR, 2'd0, 0, 0));
      q.push_back(mk("b2b_stall_2", load5(),       0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("b2b_idle",    idle(),        0, CTL_NONE,  2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_halt_drain();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("halt_behind_hazard", mk_s(1,5,1,0,0,1, 1,5,1,1,0, 0,0,0,0), 0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("halt_issue",      halt_id(), 0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("drain_1",         idle(),    0, CTL_DRAIN, 2'd1, 0, 0));
      q.push_back(mk("drain_2",         idle(),    0, CTL_DRAIN, 2'd1, 0, 0));
      q.push_back(mk("drain_3",         idle(),    0, CTL_DRAIN, 2'd1, 0, 0));
      q.push_back(mk("drain_retire",    mk_s(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,1), 0, CTL_DRAIN, 2'd1, 0, 0));
      q.push_back(mk("halted_1",        idle(),    0, CTL_HALT,  2'd2, 1, 0));
      q.push_back(mk("halted_redirect", mk_s(0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0), 0, CTL_HALT, 2'd2, 1, 0));
      q.push_back(mk("halted_hazard",   load5(),   0, CTL_HALT,  2'd2, 1, 0));
      q.push_back(mk("halted_rst",      idle(),    1, CTL_HALT,  2'd2, 1, 0));
      q.push_back(mk("after_halt_rst",  idle(),    0, CTL_NONE,  2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_drain_exit();
      step_t q[$];
      exp_t  e;
      q.push_back(mk("hazard_pre",       load5(),   0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("halt_issue_a",     halt_id(), 0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("drain_redirect",   mk_s(0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0), 0, CTL_REDIR, 2'd1, 0, 0));
      q.push_back(mk("run_after_redir",  idle(),    0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("halt_issue_b",     halt_id(), 0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("redir_beats_retire", mk_s(0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,1), 0, CTL_REDIR, 2'd1, 0, 0));
      q.push_back(mk("run_after_both",   idle(),    0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("halt_issue_c",     halt_id(), 0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("drain_rst_retire", mk_s(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,1), 1, CTL_DRAIN, 2'd1, 0, 0));
      q.push_back(mk("run_after_rst",    idle(),    0, CTL_NONE,  2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   task automatic test_saturation();
      step_t q[$];
      exp_t  e;
      applyStimulus(mk("force_setup", idle(), 0, CTL_NONE, 2'd0, 0, 0));
      void'(sb.pop_back());
      vectors--;
      force dut.stall_count_q = 32'hFFFF_FFFE;
      @(posedge i_clk);
      @(negedge i_clk);
      release dut.stall_count_q;
      exp_cnt = 32'hFFFF_FFFE;
      q.push_back(mk("sat_start",  idle(),  0, CTL_NONE,  2'd0, 0, 0));
      q.push_back(mk("sat_hz_1",   load5(), 0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("sat_hz_2",   load5(), 0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("sat_hz_3",   load5(), 0, CTL_STALL, 2'd0, 0, 1));
      q.push_back(mk("sat_hold",   idle(),  0, CTL_NONE,  2'd0, 0, 0));
      foreach (q[i]) begin
         applyStimulus(q[i]);
         #1;
         e = sb.pop_front();
         if (obs() !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h required %h", e.name, obs(), e.v);
         end
         advance(q[i]);
      end
   endtask

   initial begin
      i_rst = 1'b1;
      i_id_valid = 0; i_id_rs1_addr = 0; i_id_rs2_addr = 0; i_id_uses_rs1 = 0;
      i_id_uses_rs2 = 0; i_id_halt = 0; i_ex_valid = 0; i_ex_rd_addr = 0;
      i_ex_reg_write = 0; i_ex_mem_read = 0; i_ex_redirect = 0; i_mem_valid = 0;
      i_mem_rd_addr = 0; i_mem_reg_write = 0; i_wb_retire_halt = 0;
      @(negedge i_clk);
      @(negedge i_clk);
      $display("[TB] start, forwarding build = %0d", FWD);
      test_reset();
      test_load_use();
      test_redirect();
      test_x0_and_alu();
      test_back_to_back();
      test_halt_drain();
      test_drain_exit();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
